// File: rtl/ultrasonic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ultrasonic_scheduler
//  Purpose  : Round-robin scheduler sharing one trigger/echo timing engine
//             between N_SENS ultrasonic rangers. Fires one sensor at a time,
//             times its echo pulse, posts the result, then waits a guard
//             interval to keep acoustic crosstalk out of the next shot.
//  Revision : 1.0  initial release
// ============================================================================
module ultrasonic_scheduler #(
    parameter int N_SENS       = 4,
    parameter int ID_W         = 2,
    parameter int CNT_W        = 21,
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 1_900_000,
    parameter int GUARD_CYCLES = 500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_SENS-1:0] sensor_mask,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trigger,
    output logic              busy,
    output logic              meas_valid,
    output logic [ID_W-1:0]   meas_id,
    output logic [CNT_W-1:0]  meas_cnt,
    output logic              meas_timeout
);

    // Terminal counts for the shared counter; TRIG and GUARD count from 0,
    // so their last value is one below the cycle count.
    localparam logic [CNT_W-1:0] C_TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ECHO_TIMEOUT = CNT_W'(ECHO_TIMEOUT);
    localparam logic [CNT_W-1:0] C_GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE          = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_RISE = 3'd3,
        ST_MEASURE   = 3'd4,
        ST_GUARD     = 3'd5
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    sel;
    logic [ID_W-1:0]    last_served;
    logic [CNT_W-1:0]   cnt;
    logic [N_SENS-1:0]  echo_meta;
    logic [N_SENS-1:0]  echo_sync;
    logic               echo_s;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [N_SENS-1:0]  pick_onehot;

    // Two-flop synchroniser on every raw echo pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= '0;
            echo_sync <= '0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
        end
    end

    assign echo_s = echo_sync[sel];

    // Round-robin pick: first masked-in sensor after last_served, wrapping.
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = N_SENS; i >= 1; i--) begin
            int              cand;
            logic [ID_W-1:0] cand_id;
            cand = int'(last_served) + i;
            if (cand >= N_SENS) begin
                cand = cand - N_SENS;
            end
            cand_id = ID_W'(cand);
            if (sensor_mask[cand_id]) begin
                pick_found = 1'b1;
                pick_id    = cand_id;
            end
        end
    end

    // One-hot trigger pattern for the picked sensor.
    always_comb begin
        pick_onehot          = '0;
        pick_onehot[pick_id] = 1'b1;
    end

    // Scheduler FSM with registered trigger, busy and measurement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sel          <= '0;
            last_served  <= ID_W'(N_SENS - 1);
            cnt          <= '0;
            trigger      <= '0;
            busy         <= 1'b0;
            meas_valid   <= 1'b0;
            meas_id      <= '0;
            meas_cnt     <= '0;
            meas_timeout <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!enable) begin
                // Abort: last_served untouched so the same sensor re-fires.
                state   <= ST_IDLE;
                trigger <= '0;
                busy    <= 1'b0;
                cnt     <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SELECT;
                        busy  <= 1'b1;
                    end
                    ST_SELECT: begin
                        if (pick_found) begin
                            sel     <= pick_id;
                            trigger <= pick_onehot;
                            cnt     <= '0;
                            state   <= ST_TRIG;
                        end
                    end
                    ST_TRIG: begin
                        if (cnt >= C_TRIG_LAST) begin
                            trigger <= '0;
                            cnt     <= '0;
                            state   <= ST_WAIT_RISE;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    ST_WAIT_RISE: begin
                        if (echo_s) begin
                            cnt   <= C_ONE;
                            state <= ST_MEASURE;
                        end else if (cnt >= C_ECHO_TIMEOUT) begin
                            meas_valid   <= 1'b1;
                            meas_id      <= sel;
                            meas_cnt     <= '0;
                            meas_timeout <= 1'b1;
                            cnt          <= '0;
                            state        <= ST_GUARD;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    ST_MEASURE: begin
                        if (!echo_s) begin
                            meas_valid   <= 1'b1;
                            meas_id      <= sel;
                            meas_cnt     <= cnt;
                            meas_timeout <= 1'b0;
                            cnt          <= '0;
                            state        <= ST_GUARD;
                        end else if (cnt >= C_ECHO_TIMEOUT) begin
                            meas_valid   <= 1'b1;
                            meas_id      <= sel;
                            meas_cnt     <= C_ECHO_TIMEOUT;
                            meas_timeout <= 1'b1;
                            cnt          <= '0;
                            state        <= ST_GUARD;
                        end else begin
                            cnt <= cnt + C_ONE;
                        end
                    end
                    ST_GUARD: begin
                        // Guard is stretched while a stuck echo is still high.
                        if (cnt < C_GUARD_LAST) begin
                            cnt <= cnt + C_ONE;
                        end else if (!echo_s) begin
                            last_served <= sel;
                            state       <= ST_SELECT;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        trigger <= '0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ultrasonic_scheduler
//  Purpose  : Self-checking bench for ultrasonic_scheduler: table of mask /
//             echo-fault scenarios plus directed abort, reset and stuck-echo
//             sequences. Echo pins come from a small behavioural sensor model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ultrasonic_scheduler;

    localparam int N_SENS       = 4;
    localparam int ID_W         = 2;
    localparam int CNT_W        = 21;
    localparam int TRIG_CYCLES  = 4;
    localparam int ECHO_TIMEOUT = 100;
    localparam int GUARD_CYCLES = 20;
    localparam int ECHO_DELAY   = 5;
    localparam int ECHO_WIDTH   = 30;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [N_SENS-1:0] sensor_mask;
    logic [N_SENS-1:0] echo;
    logic [N_SENS-1:0] trigger;
    logic              busy;
    logic              meas_valid;
    logic [ID_W-1:0]   meas_id;
    logic [CNT_W-1:0]  meas_cnt;
    logic              meas_timeout;

    logic [N_SENS-1:0] stuck_lo;
    logic [N_SENS-1:0] stuck_hi;
    logic [N_SENS-1:0] pulse;

    int tests  = 0;
    int errors = 0;

    ultrasonic_scheduler #(
        .N_SENS       (N_SENS),
        .ID_W         (ID_W),
        .CNT_W        (CNT_W),
        .TRIG_CYCLES  (TRIG_CYCLES),
        .ECHO_TIMEOUT (ECHO_TIMEOUT),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sensor_mask  (sensor_mask),
        .echo         (echo),
        .trigger      (trigger),
        .busy         (busy),
        .meas_valid   (meas_valid),
        .meas_id      (meas_id),
        .meas_cnt     (meas_cnt),
        .meas_timeout (meas_timeout)
    );

    always #5 clk = ~clk;

    assign echo = (pulse & ~stuck_lo) | stuck_hi;

    // Sensor model: echo rises ECHO_DELAY cycles after trigger falls, stays ECHO_WIDTH.
    int                dly [N_SENS];
    int                wid [N_SENS];
    logic [N_SENS-1:0] model_tp;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SENS; i++) begin
                dly[i] = 0;
                wid[i] = 0;
            end
            model_tp = '0;
        end else begin
            for (int i = 0; i < N_SENS; i++) begin
                if (model_tp[i] && !trigger[i]) begin
                    dly[i] = ECHO_DELAY;
                end else if (dly[i] > 0) begin
                    dly[i] = dly[i] - 1;
                    if (dly[i] == 0) wid[i] = ECHO_WIDTH;
                end else if (wid[i] > 0) begin
                    wid[i] = wid[i] - 1;
                end
            end
            model_tp = trigger;
        end
        for (int i = 0; i < N_SENS; i++) pulse[i] = (wid[i] > 0);
    end

    // Monitor: logs trigger rises, widths, fall times and measurement strobes.
    typedef struct {
        int id;
        int cnt;
        int to;
        int cyc;
    } meas_t;

    meas_t             meas_q  [$];
    int                trig_q  [$];
    int                trigw_q [$];
    int                fall_q  [$];
    int                wcnt    [N_SENS];
    logic [N_SENS-1:0] trig_prev;
    int                cyc        = 0;
    int                onehot_bad = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            trig_prev = '0;
            for (int i = 0; i < N_SENS; i++) wcnt[i] = 0;
        end else begin
            if (meas_valid) meas_q.push_back('{int'(meas_id), int'(meas_cnt), int'(meas_timeout), cyc});
            for (int i = 0; i < N_SENS; i++) begin
                if (trigger[i]) begin
                    if (!trig_prev[i]) trig_q.push_back(i);
                    wcnt[i] = wcnt[i] + 1;
                end else if (trig_prev[i]) begin
                    trigw_q.push_back(wcnt[i]);
                    fall_q.push_back(cyc);
                    wcnt[i] = 0;
                end
            end
            if ($countones(trigger) > 1) onehot_bad = onehot_bad + 1;
            trig_prev = trigger;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        enable      = 1'b0;
        stuck_lo    = '0;
        stuck_hi    = '0;
        sensor_mask = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        meas_q.delete();
        trig_q.delete();
        trigw_q.delete();
        fall_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_meas(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (meas_q.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_trig(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (trig_q.size() >= n) break;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [N_SENS-1:0] mask;
        logic [N_SENS-1:0] lo;
        int                n;
        int                id  [5];
        int                cnt [5];
        int                to  [5];
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{4'b1111, 4'b0000, 5, '{0, 1, 2, 3, 0}, '{30, 30, 30, 30, 30}, '{0, 0, 0, 0, 0}};
        vecs[1] = '{4'b1010, 4'b0000, 4, '{1, 3, 1, 3, 0}, '{30, 30, 30, 30, 0},  '{0, 0, 0, 0, 0}};
        vecs[2] = '{4'b1111, 4'b0100, 4, '{0, 1, 2, 3, 0}, '{30, 30, 0, 30, 0},   '{0, 0, 1, 0, 0}};
        vecs[3] = '{4'b0001, 4'b0000, 3, '{0, 0, 0, 0, 0}, '{30, 30, 30, 0, 0},   '{0, 0, 0, 0, 0}};
        vecs[4] = '{4'b0100, 4'b0100, 2, '{2, 2, 0, 0, 0}, '{0, 0, 0, 0, 0},      '{1, 1, 0, 0, 0}};

        enable      = 1'b0;
        sensor_mask = '0;
        stuck_lo    = '0;
        stuck_hi    = '0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset trigger",      int'(trigger),      0);
        check("reset busy",         int'(busy),         0);
        check("reset meas_valid",   int'(meas_valid),   0);
        check("reset meas_id",      int'(meas_id),      0);
        check("reset meas_cnt",     int'(meas_cnt),     0);
        check("reset meas_timeout", int'(meas_timeout), 0);

        // Table-driven scenarios, each from a fresh reset.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            sensor_mask = vecs[v].mask;
            stuck_lo    = vecs[v].lo;
            enable      = 1'b1;
            wait_meas(vecs[v].n, 2000);
            enable = 1'b0;
            check($sformatf("v%0d strobe count", v), (meas_q.size() >= vecs[v].n) ? 1 : 0, 1);
            for (int k = 0; k < vecs[v].n; k++) begin
                int mid, mcnt, mto, tid, tw, lat;
                mid  = (k < meas_q.size())  ? meas_q[k].id  : -1;
                mcnt = (k < meas_q.size())  ? meas_q[k].cnt : -1;
                mto  = (k < meas_q.size())  ? meas_q[k].to  : -1;
                tid  = (k < trig_q.size())  ? trig_q[k]     : -1;
                tw   = (k < trigw_q.size()) ? trigw_q[k]    : -1;
                check($sformatf("v%0d[%0d] trigger order", v, k), tid,  vecs[v].id[k]);
                check($sformatf("v%0d[%0d] trigger width", v, k), tw,   TRIG_CYCLES);
                check($sformatf("v%0d[%0d] meas_id", v, k),       mid,  vecs[v].id[k]);
                check($sformatf("v%0d[%0d] meas_cnt", v, k),      mcnt, vecs[v].cnt[k]);
                check($sformatf("v%0d[%0d] meas_timeout", v, k),  mto,  vecs[v].to[k]);
                if (vecs[v].to[k] == 1) begin
                    lat = (k < meas_q.size() && k < fall_q.size()) ? meas_q[k].cyc - fall_q[k] : -1;
                    check($sformatf("v%0d[%0d] timeout latency in 98..104 (lat=%0d)", v, k, lat),
                          (lat >= 98 && lat <= 104) ? 1 : 0, 1);
                end
            end
        end

        // Stuck-high echo on sensor 1: saturated count, guard held until release.
        do_reset();
        sensor_mask = 4'b0010;
        stuck_hi    = 4'b0010;
        enable      = 1'b1;
        wait_meas(1, 500);
        check("stuck-high meas_id",      (meas_q.size() > 0) ? meas_q[0].id  : -1, 1);
        check("stuck-high meas_cnt",     (meas_q.size() > 0) ? meas_q[0].cnt : -1, ECHO_TIMEOUT);
        check("stuck-high meas_timeout", (meas_q.size() > 0) ? meas_q[0].to  : -1, 1);
        repeat (60) @(negedge clk);
        check("stuck-high guard holds (triggers)", trig_q.size(), 1);
        check("stuck-high guard busy", int'(busy), 1);
        stuck_hi = '0;
        wait_trig(2, 200);
        check("stuck-high refire after release", (trig_q.size() > 1) ? trig_q[1] : -1, 1);
        enable = 1'b0;

        // Enable dropped mid-MEASURE on sensor 3; resume re-fires sensor 3.
        do_reset();
        sensor_mask = 4'b1111;
        enable      = 1'b1;
        wait_trig(4, 1500);
        check("abort reached sensor 3", (trig_q.size() > 3) ? trig_q[3] : -1, 3);
        for (int i = 0; i < 50; i++) begin
            if (!trigger[3]) break;
            @(negedge clk);
        end
        repeat (15) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort trigger low", int'(trigger), 0);
        check("abort busy low",    int'(busy),    0);
        repeat (50) @(negedge clk);
        check("abort no strobe", meas_q.size(), 3);
        enable = 1'b1;
        wait_trig(5, 200);
        check("resume fires sensor 3", (trig_q.size() > 4) ? trig_q[4] : -1, 3);
        wait_meas(4, 300);
        check("resume meas_id",  (meas_q.size() > 3) ? meas_q[3].id  : -1, 3);
        check("resume meas_cnt", (meas_q.size() > 3) ? meas_q[3].cnt : -1, ECHO_WIDTH);
        enable = 1'b0;

        // Empty mask parks in SELECT; setting a bit starts that sensor.
        do_reset();
        sensor_mask = 4'b0000;
        enable      = 1'b1;
        repeat (20) @(negedge clk);
        check("empty mask busy",     int'(busy),    1);
        check("empty mask triggers", trig_q.size(), 0);
        sensor_mask = 4'b0100;
        wait_trig(1, 50);
        check("mask set fires sensor 2", (trig_q.size() > 0) ? trig_q[0] : -1, 2);
        enable = 1'b0;

        // Async reset in the middle of a trigger pulse.
        do_reset();
        sensor_mask = 4'b1111;
        enable      = 1'b1;
        wait_trig(2, 500);
        @(negedge clk);
        check("pre-reset trigger high", int'(trigger), 4'b0010);
        rst_n = 1'b0;
        #1;
        check("async reset trigger", int'(trigger), 0);
        check("async reset busy",    int'(busy),    0);
        @(negedge clk);
        trig_q.delete();
        rst_n = 1'b1;
        wait_trig(1, 50);
        check("post-reset first fire", (trig_q.size() > 0) ? trig_q[0] : -1, 0);
        enable = 1'b0;

        check("trigger one-hot", onehot_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
